rst_req_gen: RTL and testbench
==============================

RST_REQ_GEN -- requirements
Module: rst_req_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 8, consecutive synchronized-low cycles needed to accept a button press (>=2).
REQ-002 Parameter HOLD_CYCLES, 16, minimum sys_rst_n low width in clk cycles (>=1).
REQ-003 Parameter COOLDOWN_CYCLES, 4, post-release cycles during which all requests are ignored (>=1).
REQ-004 Port clk  input  1  system clock; all state on posedge clk.
REQ-005 Port rst  input  1  reset rst, asynchronous, active-low.
REQ-006 Port btn_n  input  1  raw pushbutton reset request, active-low, asynchronous to clk, may bounce.
REQ-007 Port sw_req  input  1  synchronous software reset request, active-high, single-cycle pulse or level.
REQ-008 Port sys_rst_n  output  1  generated system reset, active-low, registered, glitch-free; feeds downstream reset synchronizers.
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port cause  output  2  last reset source: 00 power-on, 01 button, 10 software; 11 unused.

Function
REQ-011 btn_n SHALL pass through a 2-flop synchronizer, giving btn_s; latency 2 cycles.
REQ-012 FSM states SHALL be IDLE, DEBOUNCE, ASSERT, WAIT_REL, COOLDOWN.
REQ-013 IDLE: sw_req=1 -> ASSERT, cause=10; else btn_s=0 -> DEBOUNCE, counter cleared; else stay.
REQ-014 sw_req and btn_s=0 together in IDLE SHALL go to ASSERT with cause=10.
REQ-015 DEBOUNCE: btn_s=1 on any cycle -> IDLE, no reset issued (glitch rejected).
REQ-016 DEBOUNCE: btn_s=0 for DEBOUNCE_CYCLES consecutive cycles, counting the entry cycle -> ASSERT, cause=01.
REQ-017 DEBOUNCE: sw_req=1 -> ASSERT, cause=10, even if debounce is incomplete.
REQ-018 ASSERT SHALL last exactly HOLD_CYCLES cycles, then -> WAIT_REL if btn_s=0, else -> COOLDOWN.
REQ-019 WAIT_REL: stay while btn_s=0; btn_s=1 -> COOLDOWN.
REQ-020 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then -> IDLE.
REQ-021 sw_req and btn_s SHALL be ignored in ASSERT and COOLDOWN.
REQ-022 sys_rst_n SHALL be a flop loaded from next-state: 0 exactly while the state is ASSERT or WAIT_REL, 1 otherwise.
REQ-023 A sw_req sampled at edge k in IDLE SHALL drive sys_rst_n low from edge k for HOLD_CYCLES cycles.
REQ-024 busy SHALL be registered and equal (state != IDLE).
REQ-025 cause SHALL update only on entry to ASSERT and hold its value otherwise.
REQ-026 Shared cycle counter width SHALL be $clog2 of the largest parameter, plus 1; it clears on every state change and never wraps.

Reset
REQ-027 rst=0 SHALL immediately force state=ASSERT, counter=0, sync flops=1, sys_rst_n=0, busy=1, cause=00.
REQ-028 After rst deasserts, sys_rst_n SHALL stay low HOLD_CYCLES further cycles (power-on stretch), then follow REQ-018.
REQ-029 rst asserted in any state, mid-count included, SHALL abort that state and apply REQ-027.

Structure
REQ-030 Package rst_req_pkg SHALL hold the state enum, the cause enum (CAUSE_POR, CAUSE_BTN, CAUSE_SW) and the default parameter constants.
REQ-031 The synchronizer SHALL be a sub-module sync_2ff (async active-low reset, reset value 1), instantiated once.
REQ-032 No combinational path SHALL exist from any input to sys_rst_n or busy.

Verification (defaults 8/16/4)
REQ-033 Power-on: rst low 3 cycles, btn_n=1 -> sys_rst_n low through 16 edges after release, busy falls 4 cycles later, cause=00.
REQ-034 Glitch: btn_n low 5 cycles in IDLE -> sys_rst_n stays 1, FSM returns to IDLE, cause unchanged.
REQ-035 Press: btn_n low 12 cycles -> sys_rst_n low exactly 16 cycles, starting 10 cycles after the press (2 sync + 8 debounce); cause=01.
REQ-036 Held button: btn_n low 100 cycles -> sys_rst_n low until 2 cycles after release, then 4 COOLDOWN cycles, then IDLE.
REQ-037 Software: 1-cycle sw_req in IDLE -> sys_rst_n low next 16 cycles, cause=10; second sw_req during COOLDOWN ignored.
REQ-038 Mid-operation reset: rst pulsed low during WAIT_REL -> sys_rst_n stays 0, cause=00, full 16-cycle hold restarts after release.

Source files
------------

// File: rtl/rst_req_pkg.sv
// rtl/rst_req_pkg.sv - shared types and default timing for the reset request generator
package rst_req_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ASSERT   = 3'd2,
    ST_WAIT_REL = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_SW  = 2'b10
  } cause_t;

  localparam int DEF_DEBOUNCE_CYCLES = 8;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_COOLDOWN_CYCLES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to 1 so an idle active-low input reads released
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_req_gen.sv
// rtl/rst_req_gen.sv - debounced button / software reset request FSM producing a stretched system reset
module rst_req_gen
  import rst_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_n,
  input  logic       sw_req,
  output logic       sys_rst_n,
  output logic       busy,
  output logic [1:0] cause
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, COOLDOWN_CYCLES)) + 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        state, next_state;
  cause_t        cause_q, next_cause;
  logic [CW-1:0] cnt;
  logic          btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_n),
    .q   (btn_s)
  );

  always_comb begin
    next_state = state;
    next_cause = cause_q;
    case (state)
      ST_IDLE: begin
        if (sw_req) begin
          next_state = ST_ASSERT;
          next_cause = CAUSE_SW;
        end else if (!btn_s) begin
          next_state = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        // Software request wins over both glitch rejection and an unfinished debounce.
        if (sw_req) begin
          next_state = ST_ASSERT;
          next_cause = CAUSE_SW;
        end else if (btn_s) begin
          next_state = ST_IDLE;
        end else if (cnt == DB_LAST) begin
          next_state = ST_ASSERT;
          next_cause = CAUSE_BTN;
        end
      end
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) next_state = btn_s ? ST_COOLDOWN : ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (btn_s) next_state = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt == CD_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs load from next_state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ASSERT;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
      busy      <= 1'b1;
      cause_q   <= CAUSE_POR;
    end else begin
      state     <= next_state;
      cnt       <= (next_state != state) ? '0 :
                   (cnt == CNT_MAX)      ? cnt : cnt + CW'(1);
      sys_rst_n <= !((next_state == ST_ASSERT) || (next_state == ST_WAIT_REL));
      busy      <= (next_state != ST_IDLE);
      cause_q   <= next_cause;
    end
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_rst_req_gen.sv
// tb/tb_rst_req_gen.sv - directed self-checking bench for rst_req_gen with default 8/16/4 timing
module tb_rst_req_gen;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       sw_req;
  logic       sys_rst_n;
  logic       busy;
  logic [1:0] cause;

  int checks;
  int failures;
  int first_low;
  int last_low;
  int low_cnt;
  int busy_last;

  rst_req_gen dut (
    .clk       (clk),
    .rst       (rst),
    .btn_n     (btn_n),
    .sw_req    (sw_req),
    .sys_rst_n (sys_rst_n),
    .busy      (busy),
    .cause     (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step i drives inputs for edge i+1, then samples outputs after that edge as index i+1.
  task automatic run(input int n, input int btn_low, input int sw_a, input int sw_b, input int rst_at);
    first_low = -1;
    last_low  = -1;
    low_cnt   = 0;
    busy_last = -1;
    for (int i = 0; i < n; i++) begin
      btn_n  = (i < btn_low) ? 1'b0 : 1'b1;
      sw_req = (i == sw_a || i == sw_b) ? 1'b1 : 1'b0;
      rst    = (i == rst_at) ? 1'b0 : 1'b1;
      tick();
      if (!sys_rst_n) begin
        if (first_low < 0) first_low = i + 1;
        last_low = i + 1;
        low_cnt++;
      end
      if (busy) busy_last = i + 1;
    end
    btn_n  = 1'b1;
    sw_req = 1'b0;
    rst    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    btn_n    = 1'b1;
    sw_req   = 1'b0;
    repeat (3) tick();
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cause", int'(cause), 0);

    rst = 1'b1;
    run(30, 0, -1, -1, -1);
    check("por_first_low", first_low, 1);
    check("por_last_low", last_low, 15);
    check("por_busy_last", busy_last, 19);
    check("por_cause", int'(cause), 0);

    run(20, 5, -1, -1, -1);
    check("glitch_low_cnt", low_cnt, 0);
    check("glitch_busy_last", busy_last, 7);
    check("glitch_idle", int'(busy), 0);
    check("glitch_cause", int'(cause), 0);

    run(40, 12, -1, -1, -1);
    check("press_first_low", first_low, 11);
    check("press_last_low", last_low, 26);
    check("press_low_cnt", low_cnt, 16);
    check("press_busy_last", busy_last, 30);
    check("press_cause", int'(cause), 1);

    run(120, 100, -1, -1, -1);
    check("held_first_low", first_low, 11);
    check("held_last_low", last_low, 102);
    check("held_low_cnt", low_cnt, 92);
    check("held_busy_last", busy_last, 106);

    run(30, 0, 0, 18, -1);
    check("sw_first_low", first_low, 1);
    check("sw_last_low", last_low, 16);
    check("sw_low_cnt", low_cnt, 16);
    check("sw_busy_last", busy_last, 20);
    check("sw_cause", int'(cause), 2);

    run(40, 12, -1, -1, -1);
    check("press2_cause", int'(cause), 1);
    run(30, 12, 2, -1, -1);
    check("sw_btn_first_low", first_low, 3);
    check("sw_btn_last_low", last_low, 18);
    check("sw_btn_cause", int'(cause), 2);

    run(40, 12, -1, -1, -1);
    run(30, 12, 5, -1, -1);
    check("sw_db_first_low", first_low, 6);
    check("sw_db_last_low", last_low, 21);
    check("sw_db_busy_last", busy_last, 25);
    check("sw_db_cause", int'(cause), 2);

    run(40, 12, -1, -1, -1);
    run(60, 40, -1, -1, 30);
    check("mid_first_low", first_low, 11);
    check("mid_last_low", last_low, 46);
    check("mid_low_cnt", low_cnt, 36);
    check("mid_busy_last", busy_last, 50);
    check("mid_cause", int'(cause), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
